// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between two requesters. A request is
//   accepted in IDLE and its operands are latched. The operands are presented
//   to the ALU for one EXEC cycle, and the result is held in RESP until the
//   consumer takes it.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/ctl/a/b/ready    requester N (N = 0,1) operation channel
//   alu_ctl, alu_in1, alu_in2   drive to the shared ALU
//   alu_out, alu_zero           shared ALU result and zero flag
//   rsp_valid/id/data/zero      response channel, rsp_ready from consumer
//   busy                        high whenever the FSM is not idle
//   dbg_state                   current FSM state (0 idle, 1 exec, 2 resp)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A requester's ready never depends on that requester's own data,
// only on its valid, the other valid, the FSM state and the fairness bit.
// A response stays valid, with its payload unchanged, until it is taken.
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter logic [3:0] IDLE_CTL = 4'b0011
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [3:0]  req0_ctl,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [3:0]  req1_ctl,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic [3:0]  alu_ctl,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_zero,
  input  logic        rsp_ready,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state;
  logic        last_grant;
  logic        op_id;
  logic [3:0]  op_ctl;
  logic [31:0] op_a;
  logic [31:0] op_b;

  logic        grant0;
  logic        grant1;
  logic        accept;

  // On a tie the requester that did not win last time gets the grant.
  assign grant0 = req0_valid && (!req1_valid || last_grant);
  assign grant1 = req1_valid && (!req0_valid || !last_grant);

  assign req0_ready = (state == ST_IDLE) && grant0;
  assign req1_ready = (state == ST_IDLE) && grant1;
  assign accept     = req0_ready || req1_ready;

  // The ALU sees the latched operands only while executing. Outside EXEC it
  // sees the unused idle code with zero operands.
  assign alu_ctl = (state == ST_EXEC) ? op_ctl : IDLE_CTL;
  assign alu_in1 = (state == ST_EXEC) ? op_a   : 32'd0;
  assign alu_in2 = (state == ST_EXEC) ? op_b   : 32'd0;

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      op_id      <= 1'b0;
      op_ctl     <= 4'd0;
      op_a       <= 32'd0;
      op_b       <= 32'd0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= 32'd0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            // req1_ready high means requester 1 won, otherwise requester 0.
            op_id      <= req1_ready;
            op_ctl     <= req1_ready ? req1_ctl : req0_ctl;
            op_a       <= req1_ready ? req1_a   : req0_a;
            op_b       <= req1_ready ? req1_b   : req0_b;
            last_grant <= req1_ready;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data  <= alu_out;
          rsp_zero  <= alu_zero;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
